pipeline_sequencer: RTL and testbench
=====================================

Name: pipeline_sequencer

Overview:
- Hazard and control sequencer for the 5-stage CPU datapath. Drives the datapath's hazard-unit interface: stalls, program-counter source select, instruction-word injection and the interrupt/exception vector address.
- Arbitrates between pipeline stall requests, branches, returns, halt, illegal-opcode exceptions and 8 prioritised interrupt requests.
- Interrupts enter the pipeline as an injected CALL word, so the call stack saves the return address through the normal path.

Parameters:
NOP_WORD, 32'h0000_0000, instruction word injected to squash or bubble a slot
INT_CALL_OPCODE, 8'h3C, opcode placed in bits [7:0] of the injected interrupt CALL
VECTOR_BASE, 14'h0010, address of IRQ0 handler; IRQn handler = VECTOR_BASE + 4*n
EXC_VECTOR, 14'h0004, illegal-opcode handler address
RET_LATENCY, 3, cycles from return_in_pipeline until the return address is valid at MEM/WB; minimum 1

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
stall_fetch_req  in  1  decode requests fetch stall
stall_decode_req  in  1  decode requests decode stall
halt  in  1  decoded HALT
take_branch_target  in  1  decode resolved a taken branch
illegal_opcode_exception  in  1  decode saw an illegal opcode
return_in_pipeline  in  1  RET entered ID/EX
irq_req  in  8  level interrupt requests; bit 0 has highest priority
irq_mask  in  8  per-line enable
global_int_en  in  1  global interrupt enable
exc_clear  in  1  clears exc_pending
stall_fetch  out  1  to fetch stage
stall_decode  out  1  to ID/EX register
hazard_prog_cntr_sel  out  4  PC source: 0 = increment, 1 = hold, 2 = branch target, 3 = interrupt address, 4 = return address; 5-15 reserved
inst_word_sel  out  1  0 = memory word, 1 = hazard_inst_word
hazard_inst_word  out  32  injected word
prog_cntr_int_addr  out  14  vector address
irq_ack  out  8  one-hot, 1-cycle acknowledge
exc_pending  out  1  sticky illegal-opcode flag
halted  out  1  high in HALTED

Behaviour:
- Structure: state register (RUN, RET_WAIT, HALTED), return counter, isr_active flag and exc_pending flag are registered. All other outputs are combinational from the current state and inputs, so a redirect takes effect in the same cycle.
- Reset state: state = RUN, counter = 0, isr_active = 0, exc_pending = 0.
- Default outputs (all states unless a rule below overrides): stall_fetch = 0, stall_decode = 0, sel = 0, inst_word_sel = 0, hazard_inst_word = NOP_WORD, prog_cntr_int_addr = 0, irq_ack = 0, halted = 0.
- Reset mid-operation: everything returns to the reset state next cycle; any pending ack or return is dropped.
- irq_pend = global_int_en & ~isr_active & |(irq_req & irq_mask). Winner i = lowest set bit of (irq_req & irq_mask).
- RUN, first matching rule wins:
  1. illegal_opcode_exception: sel = 3, int_addr = EXC_VECTOR, inst_word_sel = 1 (NOP squash), exc_pending <= 1.
  2. take_branch_target: sel = 2, inst_word_sel = 1 (NOP).
  3. return_in_pipeline: sel = 1, stall_fetch = 1, inst_word_sel = 1 (NOP), counter <= RET_LATENCY, next state RET_WAIT.
  4. stall_fetch_req | stall_decode_req: stall_fetch = stall_fetch_req | stall_decode_req, stall_decode = stall_decode_req, sel = 1. Interrupts are deferred.
  5. halt: sel = 1, stall_fetch = 1, inst_word_sel = 1 (NOP), next state HALTED.
  6. irq_pend: sel = 3, int_addr = VECTOR_BASE + {i, 2'b00}, inst_word_sel = 1, hazard_inst_word = {int_addr, 10'd0, INT_CALL_OPCODE}, irq_ack[i] = 1, isr_active <= 1.
  7. Otherwise: defaults.
- RET_WAIT:
  - While counter > 1: stall_fetch = 1, sel = 1, inst_word_sel = 1 (NOP); counter decrements each cycle.
  - When counter == 1: sel = 4, stall_fetch = 0, inst_word_sel = 1 (NOP), isr_active <= 0, next state RUN.
  - Branch, exception and irq inputs are ignored in this state.
- HALTED: halted = 1, stall_fetch = 1, sel = 1, inst_word_sel = 1 (NOP).
  - irq_pend: perform the rule-6 injection, next state RUN.
  - A masked-in request present but global_int_en = 0: sel = 0, no ack, next state RUN (wake without vectoring).
  - Otherwise stay in HALTED.
- exc_pending: set by rule 1. exc_clear clears it; if set and clear occur in the same cycle, set wins.
- Interrupt rules:
  - Requests are level-sensitive; a requester must drop its line after irq_ack.
  - No nesting: isr_active blocks acceptance until the next return completes.
  - An irq coincident with exception, branch, return or stall stays pending and is accepted on the first eligible RUN cycle.
- Arithmetic: vector sum is 14 bits and wraps modulo 2^14. Counter width = clog2(RET_LATENCY+1).

Test Plan:
- Reset held 2 cycles with inputs toggling -> all outputs 0, hazard_inst_word = 0, state RUN; first cycle after reset sel = 0.
- take_branch_target and irq_req = 8'h01 (mask 8'hFF, global_int_en = 1) together -> cycle 0: sel = 2, NOP, no ack; cycle 1: sel = 3, int_addr = 14'h0010, hazard_inst_word = 32'h0040_003C, irq_ack = 8'h01.
- irq_req = 8'h0C, mask 8'h08 -> ack 8'h08, int_addr = 14'h001C; a second irq is ignored until return_in_pipeline, then stall_fetch high for exactly 2 cycles, sel = 4 on the 3rd cycle, and the pending irq is accepted the following cycle.
- illegal_opcode_exception -> sel = 3, int_addr = 14'h0004, exc_pending = 1; exc_pending stays 1 until exc_clear, and set-with-clear in the same cycle leaves it 1.
- halt -> halted = 1 and stall_fetch = 1 indefinitely; irq_req = 8'h80 with global_int_en = 0 -> wake with sel = 0, no ack; repeat with global_int_en = 1 -> ack 8'h80, int_addr = 14'h002C.
- stall_decode_req pulse during irq_pend -> stall_fetch = 1, stall_decode = 1, sel = 1, no ack; ack occurs the next cycle. Reset asserted in RET_WAIT -> state RUN and counter 0 next cycle.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: hazard/control sequencer for the 5-stage datapath.
// Ports: clock, reset (sync, active-high);
//   in : stall_fetch_req, stall_decode_req, halt, take_branch_target,
//        illegal_opcode_exception, return_in_pipeline, irq_req[7:0],
//        irq_mask[7:0], global_int_en, exc_clear
//   out: stall_fetch, stall_decode, hazard_prog_cntr_sel[3:0], inst_word_sel,
//        hazard_inst_word[31:0], prog_cntr_int_addr[13:0], irq_ack[7:0],
//        exc_pending, halted
module pipeline_sequencer #(
   parameter logic [31:0] NOP_WORD        = 32'h0000_0000,
   parameter logic [7:0]  INT_CALL_OPCODE = 8'h3C,
   parameter logic [13:0] VECTOR_BASE     = 14'h0010,
   parameter logic [13:0] EXC_VECTOR      = 14'h0004,
   parameter int          RET_LATENCY     = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall_fetch_req,
   input  logic        stall_decode_req,
   input  logic        halt,
   input  logic        take_branch_target,
   input  logic        illegal_opcode_exception,
   input  logic        return_in_pipeline,
   input  logic [7:0]  irq_req,
   input  logic [7:0]  irq_mask,
   input  logic        global_int_en,
   input  logic        exc_clear,
   output logic        stall_fetch,
   output logic        stall_decode,
   output logic [3:0]  hazard_prog_cntr_sel,
   output logic        inst_word_sel,
   output logic [31:0] hazard_inst_word,
   output logic [13:0] prog_cntr_int_addr,
   output logic [7:0]  irq_ack,
   output logic        exc_pending,
   output logic        halted
);
   localparam int CW = $clog2(RET_LATENCY + 1);
   typedef enum logic [1:0] {RUN, RET_WAIT, HALTED} state_t;
   state_t state, nxt;
   logic [CW-1:0] cnt;
   logic isr_active, irq_pend, take_irq, exc_set, ret_done;
   logic [7:0] req;
   logic [2:0] win;
   logic [13:0] vec;
   assign req = irq_req & irq_mask;
   assign irq_pend = global_int_en & ~isr_active & (|req);
   assign vec = VECTOR_BASE + {9'd0, win, 2'b00};
   assign ret_done = state == RET_WAIT && cnt <= CW'(1);
   // scan downwards so the lowest set line is the last one written
   always_comb begin
      win = '0;
      for (int i = 7; i >= 0; i--) if (req[i]) win = 3'(i);
   end
   // reset masks every redirect so a pending ack or return is dropped at once
   always_comb begin
      stall_fetch = 1'b0;
      stall_decode = 1'b0;
      hazard_prog_cntr_sel = 4'd0;
      inst_word_sel = 1'b0;
      hazard_inst_word = NOP_WORD;
      prog_cntr_int_addr = '0;
      irq_ack = '0;
      halted = 1'b0;
      nxt = state;
      take_irq = 1'b0;
      exc_set = 1'b0;
      if (!reset) begin
         case (state)
            RUN:
               if (illegal_opcode_exception) begin
                  hazard_prog_cntr_sel = 4'd3;
                  prog_cntr_int_addr = EXC_VECTOR;
                  inst_word_sel = 1'b1;
                  exc_set = 1'b1;
               end else if (take_branch_target) begin
                  hazard_prog_cntr_sel = 4'd2;
                  inst_word_sel = 1'b1;
               end else if (return_in_pipeline) begin
                  hazard_prog_cntr_sel = 4'd1;
                  stall_fetch = 1'b1;
                  inst_word_sel = 1'b1;
                  nxt = RET_WAIT;
               end else if (stall_fetch_req | stall_decode_req) begin
                  stall_fetch = 1'b1;
                  stall_decode = stall_decode_req;
                  hazard_prog_cntr_sel = 4'd1;
               end else if (halt) begin
                  hazard_prog_cntr_sel = 4'd1;
                  stall_fetch = 1'b1;
                  inst_word_sel = 1'b1;
                  nxt = HALTED;
               end else take_irq = irq_pend;
            RET_WAIT:
               if (!ret_done) begin
                  stall_fetch = 1'b1;
                  hazard_prog_cntr_sel = 4'd1;
                  inst_word_sel = 1'b1;
               end else begin
                  hazard_prog_cntr_sel = 4'd4;
                  inst_word_sel = 1'b1;
                  nxt = RUN;
               end
            HALTED: begin
               halted = 1'b1;
               if (irq_pend) begin
                  take_irq = 1'b1;
                  nxt = RUN;
               end else if ((|req) && !global_int_en) nxt = RUN;
               else begin
                  stall_fetch = 1'b1;
                  hazard_prog_cntr_sel = 4'd1;
                  inst_word_sel = 1'b1;
               end
            end
            default: nxt = RUN;
         endcase
      end
      // interrupt enters as an injected CALL so the return address is stacked normally
      if (take_irq) begin
         hazard_prog_cntr_sel = 4'd3;
         prog_cntr_int_addr = vec;
         inst_word_sel = 1'b1;
         hazard_inst_word = {vec, 10'd0, INT_CALL_OPCODE};
         irq_ack = 8'd1 << win;
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= RUN;
         cnt <= '0;
         isr_active <= 1'b0;
         exc_pending <= 1'b0;
      end else begin
         state <= nxt;
         cnt <= (state == RUN && nxt == RET_WAIT) ? CW'(RET_LATENCY) :
                (state == RET_WAIT && !ret_done) ? cnt - CW'(1) : '0;
         isr_active <= take_irq | (isr_active & ~ret_done);
         exc_pending <= exc_set | (exc_pending & ~exc_clear);
      end
   end
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: directed bench with a behavioural sequencer model.
module tb_pipeline_sequencer;
   logic clk = 1'b0;
   logic reset, sfr, sdr, halt, br, ill, ret, gie, exc_clear;
   logic [7:0] irq_req, irq_mask;
   logic stall_fetch, stall_decode, inst_word_sel, exc_pending, halted;
   logic [3:0] sel;
   logic [31:0] word;
   logic [13:0] addr;
   logic [7:0] ack;
   int checks = 0, failures = 0;
   pipeline_sequencer dut (
      .clock(clk), .reset(reset), .stall_fetch_req(sfr), .stall_decode_req(sdr),
      .halt(halt), .take_branch_target(br), .illegal_opcode_exception(ill),
      .return_in_pipeline(ret), .irq_req(irq_req), .irq_mask(irq_mask),
      .global_int_en(gie), .exc_clear(exc_clear), .stall_fetch(stall_fetch),
      .stall_decode(stall_decode), .hazard_prog_cntr_sel(sel),
      .inst_word_sel(inst_word_sel), .hazard_inst_word(word),
      .prog_cntr_int_addr(addr), .irq_ack(ack), .exc_pending(exc_pending),
      .halted(halted)
   );
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
      end
   endtask
   // model: ret_left = cycles still owed to a return, asleep = halted, isr = handler running
   int ret_left = 0, n_ret = 0;
   bit asleep = 0, isr = 0, exc = 0, n_sleep = 0, n_isr = 0, n_exc = 0, model_ok = 0;
   always @(negedge clk) begin
      bit e_sf, e_sd, e_iws, e_halt, pend, inject, set;
      int e_sel, w;
      logic [13:0] e_addr;
      logic [31:0] e_word;
      logic [7:0] r, e_ack;
      e_sf = 0; e_sd = 0; e_iws = 0; e_halt = 0; e_sel = 0; e_addr = 0; e_word = 0; e_ack = 0;
      inject = 0; set = 0;
      n_ret = ret_left; n_sleep = asleep; n_isr = isr;
      r = irq_req & irq_mask;
      pend = gie && !isr && r != 0;
      w = 0;
      for (int i = 7; i >= 0; i--) if (r[i]) w = i;
      if (reset) begin
         n_ret = 0; n_sleep = 0; n_isr = 0;
      end else if (ret_left > 1) begin
         e_sf = 1; e_sel = 1; e_iws = 1; n_ret = ret_left - 1;
      end else if (ret_left == 1) begin
         e_sel = 4; e_iws = 1; n_ret = 0; n_isr = 0;
      end else if (asleep) begin
         e_halt = 1;
         if (pend) begin inject = 1; n_sleep = 0; end
         else if (r != 0 && !gie) n_sleep = 0;
         else begin e_sf = 1; e_sel = 1; e_iws = 1; end
      end else if (ill) begin
         e_sel = 3; e_addr = 14'h0004; e_iws = 1; set = 1;
      end else if (br) begin
         e_sel = 2; e_iws = 1;
      end else if (ret) begin
         e_sel = 1; e_sf = 1; e_iws = 1; n_ret = 3;
      end else if (sfr || sdr) begin
         e_sf = 1; e_sd = sdr; e_sel = 1;
      end else if (halt) begin
         e_sel = 1; e_sf = 1; e_iws = 1; n_sleep = 1;
      end else inject = pend;
      if (inject) begin
         e_sel = 3; e_iws = 1; e_addr = 14'((16 + 4 * w) % 16384);
         e_word = e_addr * 32'h0004_0000 + 32'h3C;
         e_ack = 8'(1 << w); n_isr = 1;
      end
      n_exc = reset ? 0 : set ? 1 : exc_clear ? 0 : exc;
      if (model_ok) begin
         chk("m_stall_fetch", stall_fetch, e_sf);
         chk("m_stall_decode", stall_decode, e_sd);
         chk("m_sel", sel, e_sel);
         chk("m_inst_word_sel", inst_word_sel, e_iws);
         chk("m_inst_word", word, e_word);
         chk("m_int_addr", addr, e_addr);
         chk("m_irq_ack", ack, e_ack);
         chk("m_halted", halted, e_halt);
         chk("m_exc_pending", exc_pending, exc);
      end
   end
   always @(posedge clk) begin
      if (reset) begin
         ret_left <= 0; asleep <= 0; isr <= 0; exc <= 0; model_ok <= 1;
      end else if (model_ok) begin
         ret_left <= n_ret; asleep <= n_sleep; isr <= n_isr; exc <= n_exc;
      end
   end
   task automatic nc();
      @(posedge clk);
      #1;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         nc();
         {sfr, sdr, halt, br, ill, ret, exc_clear} = '0;
         irq_req = 0;
      end
   endtask
   initial begin
      reset = 1; {sfr, sdr, halt, br, ill, ret, gie, exc_clear} = '0;
      irq_req = 0; irq_mask = 0;
      nc(); br = 1; irq_req = 8'h01; irq_mask = 8'hFF; gie = 1; #2;
      chk("rst_sel", sel, 0); chk("rst_ack", ack, 0); chk("rst_word", word, 0);
      chk("rst_iws", inst_word_sel, 0); chk("rst_exc", exc_pending, 0);
      nc(); br = 0; halt = 1; ill = 1; ret = 1; #2;
      chk("rst2_sel", sel, 0); chk("rst2_sf", stall_fetch, 0); chk("rst2_halted", halted, 0);
      nc(); reset = 0; {halt, ill, ret} = '0; irq_req = 0; #2;
      chk("post_rst_sel", sel, 0); chk("post_rst_exc", exc_pending, 0);
      nc(); br = 1; irq_req = 8'h01; #2;
      chk("br_sel", sel, 2); chk("br_iws", inst_word_sel, 1); chk("br_ack", ack, 0);
      nc(); br = 0; #2;
      chk("irq0_sel", sel, 3); chk("irq0_addr", addr, 14'h0010);
      chk("irq0_word", word, 32'h0040_003C); chk("irq0_ack", ack, 8'h01);
      nc(); irq_req = 0; ret = 1; #2;
      chk("ret_sel", sel, 1); chk("ret_sf", stall_fetch, 1);
      idle(2); #2; chk("ret_wait_sf", stall_fetch, 1);
      idle(1); #2; chk("ret_done_sel", sel, 4); chk("ret_done_sf", stall_fetch, 0);
      nc(); irq_req = 8'h0C; irq_mask = 8'h08; #2;
      chk("irq3_ack", ack, 8'h08); chk("irq3_addr", addr, 14'h001C);
      nc(); irq_req = 8'h01; irq_mask = 8'hFF; #2;
      chk("nest_ack", ack, 0);
      nc(); ret = 1; #2; chk("nest_ret_ack", ack, 0);
      nc(); ret = 0; #2; chk("nest_w1_sf", stall_fetch, 1);
      nc(); #2; chk("nest_w2_sf", stall_fetch, 1);
      nc(); #2; chk("nest_ret_sel", sel, 4); chk("nest_ret_ack2", ack, 0);
      nc(); #2; chk("nest_acc_ack", ack, 8'h01); chk("nest_acc_addr", addr, 14'h0010);
      nc(); irq_req = 0; ret = 1;
      idle(4);
      nc(); ill = 1; #2;
      chk("exc_sel", sel, 3); chk("exc_addr", addr, 14'h0004); chk("exc_iws", inst_word_sel, 1);
      nc(); ill = 0; #2; chk("exc_set", exc_pending, 1);
      nc(); #2; chk("exc_sticky", exc_pending, 1);
      nc(); ill = 1; exc_clear = 1;
      nc(); ill = 0; exc_clear = 0; #2; chk("exc_set_wins", exc_pending, 1);
      nc(); exc_clear = 1;
      nc(); exc_clear = 0; #2; chk("exc_cleared", exc_pending, 0);
      nc(); halt = 1; #2; chk("halt_sel", sel, 1); chk("halt_sf", stall_fetch, 1);
      nc(); halt = 0; #2; chk("halted", halted, 1); chk("halted_sf", stall_fetch, 1);
      idle(3); #2; chk("halted_still", halted, 1); chk("halted_sf2", stall_fetch, 1);
      nc(); gie = 0; irq_req = 8'h80; #2;
      chk("wake_sel", sel, 0); chk("wake_ack", ack, 0);
      nc(); #2; chk("woke", halted, 0); chk("woke_ack", ack, 0);
      nc(); irq_req = 0; gie = 1; halt = 1;
      nc(); halt = 0; #2; chk("halted2", halted, 1);
      nc(); irq_req = 8'h80; #2;
      chk("irq7_ack", ack, 8'h80); chk("irq7_addr", addr, 14'h002C);
      nc(); irq_req = 0; #2; chk("irq7_run", halted, 0);
      nc(); ret = 1;
      idle(4);
      nc(); irq_req = 8'h01; sdr = 1; #2;
      chk("stl_sf", stall_fetch, 1); chk("stl_sd", stall_decode, 1);
      chk("stl_sel", sel, 1); chk("stl_ack", ack, 0);
      nc(); sdr = 0; #2; chk("stl_then_ack", ack, 8'h01);
      nc(); irq_req = 0; ret = 1;
      nc(); ret = 0; #2; chk("rw_sf", stall_fetch, 1);
      nc(); reset = 1; #2; chk("rw_rst_sel", sel, 0);
      nc(); reset = 0; irq_req = 8'h01; #2;
      chk("rw_rst_sf", stall_fetch, 0); chk("rw_rst_ack", ack, 8'h01);
      idle(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
